// File: rtl/fb_access_scheduler_pkg.sv
// Shared parameters and types for the framebuffer access scheduler.
package fb_access_scheduler_pkg;
    localparam int PIX_W  = 4;
    localparam int PPW    = 4;
    localparam int MEM_DW = PIX_W * PPW;
    localparam int ADDR_W = 18;
    localparam int PH_W   = (PPW > 1) ? $clog2(PPW) : 1;

    localparam logic [ADDR_W-1:0] BASE_A = 18'd0;
    localparam logic [ADDR_W-1:0] BASE_B = 18'd76800;

    typedef enum logic {
        FRONT_A = 1'b0,
        FRONT_B = 1'b1
    } front_e;

    function automatic logic [ADDR_W-1:0] front_base(input front_e f);
        return (f == FRONT_B) ? BASE_B : BASE_A;
    endfunction
endpackage

// File: rtl/fb_pixel_unpacker.sv
// Phase counter and word register: decides read slots and unpacks each fetched word into pixels.
module fb_pixel_unpacker
    import fb_access_scheduler_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_active_video_area,
    input  logic [MEM_DW-1:0] i_mem_rdata,
    output logic              o_read_slot,
    output logic [PIX_W-1:0]  o_pixel,
    output logic              o_pixel_valid
);
    logic [PH_W-1:0]   r_phase;
    logic [PH_W-1:0]   r_pix_idx;
    logic              r_first;
    logic              r_pixel_valid;
    logic [MEM_DW-1:0] r_word;

    assign o_read_slot   = i_active_video_area && (r_phase == '0);
    assign o_pixel_valid = r_pixel_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase       <= '0;
            r_pix_idx     <= '0;
            r_first       <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_word        <= '0;
        end else begin
            // PPW is a power of two, so the natural wrap gives modulo-PPW counting
            r_phase       <= i_active_video_area ? r_phase + 1'b1 : '0;
            r_pix_idx     <= r_phase;
            r_first       <= o_read_slot;
            r_pixel_valid <= i_active_video_area;
            if (r_first) begin
                r_word <= i_mem_rdata;
            end
        end
    end

    // Pixel 0 comes straight from the RAM output; the rest from the latched word
    always_comb begin
        o_pixel = '0;
        if (r_pixel_valid) begin
            if (r_first) begin
                o_pixel = i_mem_rdata[PIX_W-1:0];
            end else begin
                o_pixel = r_word[r_pix_idx*PIX_W +: PIX_W];
            end
        end
    end
endmodule

// File: rtl/fb_access_scheduler.sv
// Shares one single-port framebuffer RAM between display scan-out and a pixel writer,
// with double buffering whose front/back swap happens only at the vsync falling edge.
module fb_access_scheduler
    import fb_access_scheduler_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_active_video_area,
    input  logic              i_vs,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [MEM_DW-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_swap_req,
    output logic              o_swap_ack,
    output logic [ADDR_W-1:0] o_back_base,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [MEM_DW-1:0] o_mem_wdata,
    input  logic [MEM_DW-1:0] i_mem_rdata,
    output logic [PIX_W-1:0]  o_pixel,
    output logic              o_pixel_valid
);
    front_e            r_front;
    front_e            w_front_nxt;
    logic              r_swap_pend;
    logic              w_swap_pend_nxt;
    logic              r_vs_q;
    logic              w_vs_fall;
    logic              w_read_slot;
    logic [ADDR_W-1:0] r_rd_addr;

    fb_pixel_unpacker u_unpacker (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_active_video_area (i_active_video_area),
        .i_mem_rdata         (i_mem_rdata),
        .o_read_slot         (w_read_slot),
        .o_pixel             (o_pixel),
        .o_pixel_valid       (o_pixel_valid)
    );

    assign w_vs_fall   = r_vs_q && !i_vs;
    assign o_back_base = (r_front == FRONT_A) ? BASE_B : BASE_A;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_front     <= FRONT_A;
            r_swap_pend <= 1'b0;
            r_vs_q      <= 1'b1;
        end else begin
            r_front     <= w_front_nxt;
            r_swap_pend <= w_swap_pend_nxt;
            r_vs_q      <= i_vs;
        end
    end

    // A request arriving on the edge itself is taken immediately; repeats while pending merge
    always_comb begin
        w_front_nxt     = r_front;
        w_swap_pend_nxt = r_swap_pend;
        o_swap_ack      = 1'b0;
        if (!i_rst) begin
            if (w_vs_fall && (r_swap_pend || i_swap_req)) begin
                w_front_nxt     = (r_front == FRONT_A) ? FRONT_B : FRONT_A;
                w_swap_pend_nxt = 1'b0;
                o_swap_ack      = 1'b1;
            end else if (i_swap_req) begin
                w_swap_pend_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_addr <= BASE_A;
        end else if (w_vs_fall) begin
            r_rd_addr <= front_base(w_front_nxt);
        end else if (w_read_slot) begin
            r_rd_addr <= r_rd_addr + 1'b1;
        end
    end

    // Read slot has absolute priority; every other cycle is granted to the writer
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_wr_ack    = 1'b0;
        if (!i_rst) begin
            if (w_read_slot) begin
                o_mem_en   = 1'b1;
                o_mem_addr = r_rd_addr;
            end else if (i_wr_req) begin
                o_mem_en    = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = i_wr_addr;
                o_mem_wdata = i_wr_data;
                o_wr_ack    = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fb_access_scheduler.sv
// Self-checking bench for fb_access_scheduler: directed sequences, a vector table,
// and randomized traffic against a frame-level reference model.
module tb_fb_access_scheduler;
    import fb_access_scheduler_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              ava;
    logic              vs;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [MEM_DW-1:0] wr_data;
    logic              wr_ack;
    logic              swap_req;
    logic              swap_ack;
    logic [ADDR_W-1:0] back_base;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [MEM_DW-1:0] mem_wdata;
    logic [MEM_DW-1:0] mem_rdata = '0;
    logic [PIX_W-1:0]  pixel;
    logic              pixel_valid;

    logic [MEM_DW-1:0] ram [0:(1<<ADDR_W)-1];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fb_access_scheduler dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_active_video_area (ava),
        .i_vs                (vs),
        .i_wr_req            (wr_req),
        .i_wr_addr           (wr_addr),
        .i_wr_data           (wr_data),
        .o_wr_ack            (wr_ack),
        .i_swap_req          (swap_req),
        .o_swap_ack          (swap_ack),
        .o_back_base         (back_base),
        .o_mem_en            (mem_en),
        .o_mem_we            (mem_we),
        .o_mem_addr          (mem_addr),
        .o_mem_wdata         (mem_wdata),
        .i_mem_rdata         (mem_rdata),
        .o_pixel             (pixel),
        .o_pixel_valid       (pixel_valid)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ava = 1'b0; vs = 1'b1; wr_req = 1'b0; swap_req = 1'b0;
        wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic              ava, vs, req;
        logic [ADDR_W-1:0] addr;
        logic [MEM_DW-1:0] data;
        logic              sreq;
        logic              e_en, e_we;
        logic [ADDR_W-1:0] e_addr;
        logic              e_ack, e_sack;
        logic [ADDR_W-1:0] e_bb;
    } vec_t;

    vec_t tbl [13];

    // reference model state for the randomized run
    int                m_run;
    logic [ADDR_W-1:0] m_addr;
    logic              m_front_b, m_pend, m_vs_prev, m_pv, m_acked;
    logic [PIX_W-1:0]  m_px;
    logic [MEM_DW-1:0] m_word;

    task automatic rand_cycle(input logic a, input logic v);
        logic rd, fall, e_sack, e_ack;
        logic [MEM_DW-1:0] word;
        logic [ADDR_W-1:0] e_addr;
        @(negedge clk);
        ava = a; vs = v;
        if (!wr_req || m_acked) begin
            wr_req  = ($urandom_range(0, 1) == 1);
            wr_addr = ($urandom_range(0, 3) == 0) ? BASE_B + 18'($urandom_range(0, 63))
                                                  : 18'($urandom_range(0, 63));
            wr_data = 16'($urandom);
        end
        swap_req = ($urandom_range(0, 19) == 0);
        #1;
        rd     = ava && ((m_run % PPW) == 0);
        fall   = m_vs_prev && !vs;
        e_sack = fall && (m_pend || swap_req);
        e_ack  = wr_req && !rd;
        e_addr = rd ? m_addr : (wr_req ? wr_addr : '0);
        chk("rnd_mem_en", mem_en, rd || wr_req);
        chk("rnd_mem_we", mem_we, e_ack);
        chk("rnd_mem_addr", mem_addr, e_addr);
        chk("rnd_wr_ack", wr_ack, e_ack);
        if (e_ack) chk("rnd_wdata", mem_wdata, wr_data);
        chk("rnd_swap_ack", swap_ack, e_sack);
        chk("rnd_back_base", back_base, m_front_b ? BASE_A : BASE_B);
        chk("rnd_pixel_valid", pixel_valid, m_pv);
        chk("rnd_pixel", pixel, m_px);
        word = rd ? ram[m_addr] : m_word;
        m_word = word;
        m_px = ava ? word[PIX_W*(m_run % PPW) +: PIX_W] : '0;
        m_pv = ava;
        if (fall) begin
            if (e_sack) begin
                m_front_b = !m_front_b;
                m_pend    = 1'b0;
            end
            m_addr = m_front_b ? BASE_B : BASE_A;
        end else begin
            if (rd) m_addr = m_addr + 1'b1;
            if (swap_req) m_pend = 1'b1;
        end
        m_run     = ava ? m_run + 1 : 0;
        m_vs_prev = vs;
        m_acked   = e_ack;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int npv;
        rst = 1'b1; ava = 1'b0; vs = 1'b1; wr_req = 1'b0; swap_req = 1'b0;
        wr_addr = '0; wr_data = '0;

        // word 0 / word 1 of buffer A, pixel 0 in the LSBs
        do_reset();
        ram[0] = 16'h4321;
        ram[1] = 16'h8765;
        chk("rst_back_base", back_base, BASE_B);
        chk("rst_pixel_valid", pixel_valid, 0);
        npv = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            ava = (c < 8);
            #1;
            if (c == 0) begin
                chk("t1_rd_en", mem_en, 1);
                chk("t1_rd_we", mem_we, 0);
                chk("t1_rd_addr0", mem_addr, BASE_A);
            end
            if (c == 4) chk("t1_rd_addr1", mem_addr, 1);
            if (pixel_valid) begin
                npv++;
                chk("t1_pixel", pixel, npv);
            end else begin
                chk("t1_pixel_blank", pixel, 0);
            end
        end
        chk("t1_valid_cycles", npv, 8);

        // blanking write, double swap request, swap at the vs edge, arbitration in active video
        do_reset();
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 18'd5, 16'hBEEF, 1'b0, 1'b1, 1'b1, 18'd5,     1'b1, 1'b0, 18'd76800};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 18'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 18'd0,     1'b0, 1'b0, 18'd76800};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 18'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 18'd0,     1'b0, 1'b0, 18'd76800};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 18'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 18'd0,     1'b0, 1'b1, 18'd76800};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 18'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 18'd0,     1'b0, 1'b0, 18'd0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 18'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 18'd76800, 1'b0, 1'b0, 18'd0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 18'd7, 16'h1234, 1'b0, 1'b1, 1'b1, 18'd7,     1'b1, 1'b0, 18'd0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 18'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 18'd0,     1'b0, 1'b0, 18'd0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 18'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 18'd0,     1'b0, 1'b0, 18'd0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 18'd9, 16'h5A5A, 1'b0, 1'b1, 1'b0, 18'd76801, 1'b0, 1'b0, 18'd0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 18'd9, 16'h5A5A, 1'b0, 1'b1, 1'b1, 18'd9,     1'b1, 1'b0, 18'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 18'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 18'd0,     1'b0, 1'b0, 18'd0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 18'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 18'd76800, 1'b0, 1'b0, 18'd0};
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            ava = tbl[i].ava; vs = tbl[i].vs; wr_req = tbl[i].req;
            wr_addr = tbl[i].addr; wr_data = tbl[i].data; swap_req = tbl[i].sreq;
            #1;
            chk($sformatf("tbl%0d_mem_en", i), mem_en, tbl[i].e_en);
            chk($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].e_we);
            chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_wr_ack", i), wr_ack, tbl[i].e_ack);
            chk($sformatf("tbl%0d_swap_ack", i), swap_ack, tbl[i].e_sack);
            chk($sformatf("tbl%0d_back_base", i), back_base, tbl[i].e_bb);
            if (tbl[i].e_we) chk($sformatf("tbl%0d_wdata", i), mem_wdata, tbl[i].data);
        end
        chk("t3_ram5", ram[5], 16'hBEEF);
        chk("t3_ram7", ram[7], 16'h1234);

        // reset in the middle of an active line while front is buffer B
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ava = 1'b1; vs = 1'b1; wr_req = 1'b1; swap_req = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t6_mem_en", mem_en, 0);
        chk("t6_mem_we", mem_we, 0);
        chk("t6_mem_addr", mem_addr, 0);
        chk("t6_wr_ack", wr_ack, 0);
        chk("t6_swap_ack", swap_ack, 0);
        chk("t6_pixel", pixel, 0);
        chk("t6_pixel_valid", pixel_valid, 0);
        chk("t6_back_base", back_base, BASE_B);
        @(negedge clk);
        rst = 1'b0; ava = 1'b0; wr_req = 1'b0;
        @(negedge clk);
        vs = 1'b0;
        @(negedge clk);
        vs = 1'b1; ava = 1'b1;
        #1;
        chk("t6_restart_en", mem_en, 1);
        chk("t6_restart_addr", mem_addr, BASE_A);

        // randomized frames against the reference model
        do_reset();
        for (int i = 0; i < 128; i++) begin
            ram[i]                = 16'($urandom);
            ram[int'(BASE_B) + i] = 16'($urandom);
        end
        m_run = 0; m_addr = BASE_A; m_front_b = 1'b0; m_pend = 1'b0;
        m_vs_prev = 1'b1; m_pv = 1'b0; m_px = '0; m_word = '0; m_acked = 1'b0;
        for (int f = 0; f < 30; f++) begin
            int nl;
            nl = $urandom_range(2, 5);
            for (int l = 0; l < nl; l++) begin
                int len, gap;
                len = $urandom_range(1, 12);
                gap = $urandom_range(1, 3);
                for (int k = 0; k < len; k++) rand_cycle(1'b1, 1'b1);
                for (int k = 0; k < gap; k++) rand_cycle(1'b0, 1'b1);
            end
            rand_cycle(1'b0, 1'b0);
            rand_cycle(1'b0, 1'b0);
            rand_cycle(1'b0, 1'b1);
            rand_cycle(1'b0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
